// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART Rx frame controller and its datapath.
// master = controller side, slave = datapath / line side.
// UART_RX_ERR_CNT_EN adds the error-counter clear input and the two counters.
interface uart_rx_ctrl_if;
  logic       RX_IN;
  logic [7:0] Prescale;
  logic       PAR_EN;
  logic       Strt_Glitch;
  logic       Par_Err;
  logic       Stp_Err;
  logic [7:0] Edge_Cnt;
  logic [3:0] Bit_Cnt;
  logic       Samp_En;
  logic       Strt_Chk_En;
  logic       Deser_En;
  logic       Par_Chk_En;
  logic       Stp_Chk_En;
  logic       Data_Valid;
  logic       Parity_Err;
  logic       Framing_Err;
  logic       Busy;
`ifdef UART_RX_ERR_CNT_EN
  logic       Err_Cnt_Clr;
  logic [7:0] Glitch_Cnt;
  logic [7:0] Frame_Err_Cnt;
`endif

  modport master (
    input  RX_IN, Prescale, PAR_EN, Strt_Glitch, Par_Err, Stp_Err,
    output Edge_Cnt, Bit_Cnt, Samp_En, Strt_Chk_En, Deser_En, Par_Chk_En,
           Stp_Chk_En, Data_Valid, Parity_Err, Framing_Err, Busy
`ifdef UART_RX_ERR_CNT_EN
    , input Err_Cnt_Clr, output Glitch_Cnt, Frame_Err_Cnt
`endif
  );

  modport slave (
    output RX_IN, Prescale, PAR_EN, Strt_Glitch, Par_Err, Stp_Err,
    input  Edge_Cnt, Bit_Cnt, Samp_En, Strt_Chk_En, Deser_En, Par_Chk_En,
           Stp_Chk_En, Data_Valid, Parity_Err, Framing_Err, Busy
`ifdef UART_RX_ERR_CNT_EN
    , output Err_Cnt_Clr, input Glitch_Cnt, Frame_Err_Cnt
`endif
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART Rx frame-sequencing controller: owns the per-bit edge counter and the
// data-bit counter, decodes the datapath enables from the registered state and
// issues exactly one result pulse (Data_Valid / Parity_Err / Framing_Err) per
// completed frame.
// Optional macro UART_RX_ERR_CNT_EN: adds saturating glitch and framing-error
// counters with a clear input.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [7:0] MIN_P    = 8'd8;

  state_e     state_q, state_d;
  logic [7:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] p_q, p_d;            // prescale latched at frame start
  logic       par_en_q, par_en_d;  // parity enable latched at frame start
  logic       par_flag_q, par_flag_d;
  logic       dv_q, dv_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       abort;               // START->IDLE on a glitchy start bit

  logic       bnd;
  logic [7:0] deser_pt;

  assign bnd      = (edge_q == p_q - 8'd1);
  // Majority sample lands two cycles past mid-bit; shift one cycle later.
  assign deser_pt = (p_q >> 1) + 8'd3;

  // State and counter registers; async reset returns straight to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      p_q        <= MIN_P;
      par_en_q   <= 1'b0;
      par_flag_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      p_q        <= p_d;
      par_en_q   <= par_en_d;
      par_flag_q <= par_flag_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
    end
  end

  // Next-state, counter and result-pulse logic.
  always_comb begin
    state_d    = state_q;
    edge_d     = (state_q == IDLE || bnd) ? 8'd0 : edge_q + 8'd1;
    bit_d      = bit_q;
    p_d        = p_q;
    par_en_d   = par_en_q;
    par_flag_d = par_flag_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    fe_d       = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        par_flag_d = 1'b0;
        bit_d      = '0;
        if (!bus.RX_IN) begin
          state_d  = START;
          p_d      = (bus.Prescale < MIN_P) ? MIN_P : bus.Prescale;
          par_en_d = bus.PAR_EN;
        end
      end
      START: begin
        if (bnd) begin
          bit_d = '0;
          if (bus.Strt_Glitch) begin
            state_d = IDLE;
            abort   = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bnd) begin
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bnd) begin
          par_flag_d = bus.Par_Err;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bnd) begin
          state_d    = IDLE;
          par_flag_d = 1'b0;
          // Stop-bit failure outranks a parity failure.
          if (bus.Stp_Err)     fe_d = 1'b1;
          else if (par_flag_q) pe_d = 1'b1;
          else                 dv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore enables decoded from the registered state.
  assign bus.Edge_Cnt    = edge_q;
  assign bus.Bit_Cnt     = bit_q;
  assign bus.Samp_En     = (state_q != IDLE);
  assign bus.Strt_Chk_En = (state_q == START);
  assign bus.Deser_En    = (state_q == DATA) && (edge_q == deser_pt);
  assign bus.Par_Chk_En  = (state_q == PARITY);
  assign bus.Stp_Chk_En  = (state_q == STOP);
  assign bus.Data_Valid  = dv_q;
  assign bus.Parity_Err  = pe_q;
  assign bus.Framing_Err = fe_q;
  assign bus.Busy        = (state_q != IDLE);

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
  logic [7:0] ferr_cnt_q, ferr_cnt_d;

  // Saturating error counters; clear wins over a same-cycle increment.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    ferr_cnt_d   = ferr_cnt_q;
    if (bus.Err_Cnt_Clr) begin
      glitch_cnt_d = '0;
      ferr_cnt_d   = '0;
    end else begin
      if (abort && glitch_cnt_q != 8'hFF) glitch_cnt_d = glitch_cnt_q + 8'd1;
      if (fe_d  && ferr_cnt_q   != 8'hFF) ferr_cnt_d   = ferr_cnt_q + 8'd1;
    end
  end

  // Error counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      glitch_cnt_q <= '0;
      ferr_cnt_q   <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
      ferr_cnt_q   <= ferr_cnt_d;
    end
  end

  assign bus.Glitch_Cnt    = glitch_cnt_q;
  assign bus.Frame_Err_Cnt = ferr_cnt_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives whole frames cycle by cycle and
// checks result-pulse timing, enable activity and reset behaviour.
module tb_uart_rx_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_ctrl_if u_if ();
  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (.CLK(CLK), .RST(RST), .bus(u_if));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // cycle index: value of cyc throughout cycle k is k
  always @(posedge CLK) cyc <= cyc + 1;

  int dv_n = 0, dv_at = 0, dv_prev = 0, pe_n = 0, pe_at = 0, fe_n = 0, fe_at = 0;
  int deser_n = 0, deser_bad = 0, strt_cyc = 0, par_cyc = 0, stp_cyc = 0;
  logic [7:0] exp_ec = 8'd7;

  // event recorder, sampled 1ns after each rising edge
  always begin
    @(posedge CLK);
    #1;
    if (u_if.Data_Valid)  begin dv_n++; dv_prev = dv_at; dv_at = cyc; end
    if (u_if.Parity_Err)  begin pe_n++; pe_at = cyc; end
    if (u_if.Framing_Err) begin fe_n++; fe_at = cyc; end
    if (u_if.Deser_En) begin
      deser_n++;
      if (u_if.Edge_Cnt !== exp_ec) deser_bad++;
    end
    if (u_if.Strt_Chk_En) strt_cyc++;
    if (u_if.Par_Chk_En)  par_cyc++;
    if (u_if.Stp_Chk_En)  stp_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, u_if.Edge_Cnt, u_if.Bit_Cnt, u_if.Samp_En, u_if.Strt_Chk_En,
            u_if.Deser_En, u_if.Par_Chk_En, u_if.Stp_Chk_En, u_if.Data_Valid,
            u_if.Parity_Err, u_if.Framing_Err, u_if.Busy};
  endfunction

  task automatic idle_inputs();
    u_if.RX_IN       = 1'b1;
    u_if.Prescale    = 8'd8;
    u_if.PAR_EN      = 1'b0;
    u_if.Strt_Glitch = 1'b0;
    u_if.Par_Err     = 1'b0;
    u_if.Stp_Err     = 1'b0;
  endtask

  // Called just after a falling edge; cycle c=0 is the start-detect cycle t.
  // Returns at the falling edge of cycle t+ncyc.
  task automatic frame(input logic [7:0] pre, input int p, input logic par,
                       input logic [7:0] data, input logic glitch,
                       input logic perr, input logic serr, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int pos;
      logic rx;
      pos = (c == 0) ? 0 : (c - 1) / p;
      if (c == 0)                rx = 1'b0;
      else if (pos == 0)         rx = glitch;
      else if (pos <= 8)         rx = data[3'(pos - 1)];
      else if (par && pos == 9)  rx = ^data;
      else                       rx = 1'b1;
      u_if.RX_IN = rx;
      if (c == 0) begin
        u_if.Prescale = pre;
        u_if.PAR_EN   = par;
      end else begin
        // mid-frame changes must be ignored
        u_if.Prescale = 8'd200;
        u_if.PAR_EN   = ~par;
      end
      u_if.Strt_Glitch = glitch && (c >= 1) && (pos == 0);
      u_if.Par_Err     = perr && par && (pos == 9);
      u_if.Stp_Err     = serr && (pos == (par ? 10 : 9));
      @(negedge CLK);
    end
  endtask

  initial begin
    int t, d0, p0, f0, s0, st0, pc0, sp0;
    idle_inputs();
`ifdef UART_RX_ERR_CNT_EN
    u_if.Err_Cnt_Clr = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("reset_outs", outs(), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    check("reset_cnts", {16'd0, u_if.Glitch_Cnt, u_if.Frame_Err_Cnt}, 32'd0);
`endif
    RST = 1'b1;
    @(negedge CLK);

    // A: P=8, no parity, 0xA5, good stop -> Data_Valid at t+81
    exp_ec = 8'd7;
    t = cyc; d0 = dv_n; p0 = pe_n; f0 = fe_n; s0 = deser_n;
    st0 = strt_cyc; pc0 = par_cyc; sp0 = stp_cyc;
    frame(8'd8, 8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 81);
    check("A_dv_cnt", 32'(dv_n - d0), 32'd1);
    check("A_dv_at", 32'(dv_at - t), 32'd81);
    check("A_no_err", 32'((pe_n - p0) + (fe_n - f0)), 32'd0);
    check("A_deser_cnt", 32'(deser_n - s0), 32'd8);
    check("A_deser_edge", 32'(deser_bad), 32'd0);
    check("A_start_cyc", 32'(strt_cyc - st0), 32'd8);
    check("A_par_cyc", 32'(par_cyc - pc0), 32'd0);
    check("A_stop_cyc", 32'(stp_cyc - sp0), 32'd8);
    idle_inputs();
    @(negedge CLK);
    check("A_idle_t82", outs(), 32'd0);

    // B: P=16, parity, Par_Err during PARITY -> Parity_Err at t+177
    exp_ec = 8'd11;
    t = cyc; d0 = dv_n; p0 = pe_n; s0 = deser_n; pc0 = par_cyc;
    frame(8'd16, 16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 177);
    check("B_pe_cnt", 32'(pe_n - p0), 32'd1);
    check("B_pe_at", 32'(pe_at - t), 32'd177);
    check("B_no_dv", 32'(dv_n - d0), 32'd0);
    check("B_par_cyc", 32'(par_cyc - pc0), 32'd16);
    check("B_deser_cnt", 32'(deser_n - s0), 32'd8);
    check("B_deser_edge", 32'(deser_bad), 32'd0);
    idle_inputs();
    @(negedge CLK);

    // C: start glitch -> IDLE at t+9, no pulse
    exp_ec = 8'd7;
    d0 = dv_n; p0 = pe_n; f0 = fe_n;
    frame(8'd8, 8, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 9);
    idle_inputs();
    check("C_idle_t9", outs(), 32'd0);
    @(negedge CLK);
    check("C_no_pulse", 32'((dv_n - d0) + (pe_n - p0) + (fe_n - f0)), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    check("C_glitch_cnt", 32'(u_if.Glitch_Cnt), 32'd1);
`endif

    // D: parity + stop error together -> Framing_Err only at t+89
    t = cyc; d0 = dv_n; p0 = pe_n; f0 = fe_n;
    frame(8'd8, 8, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 89);
    check("D_fe_cnt", 32'(fe_n - f0), 32'd1);
    check("D_fe_at", 32'(fe_at - t), 32'd89);
    check("D_no_pe_dv", 32'((pe_n - p0) + (dv_n - d0)), 32'd0);
    idle_inputs();
    @(negedge CLK);
`ifdef UART_RX_ERR_CNT_EN
    check("D_ferr_cnt", 32'(u_if.Frame_Err_Cnt), 32'd1);
`endif

    // E: clean parity frame right after D: sticky flag must be gone
    t = cyc; d0 = dv_n; p0 = pe_n;
    frame(8'd8, 8, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 89);
    check("E_dv_at", 32'(dv_at - t), 32'd89);
    check("E_dv_cnt", 32'(dv_n - d0), 32'd1);
    check("E_no_pe", 32'(pe_n - p0), 32'd0);
    idle_inputs();
    @(negedge CLK);
`ifdef UART_RX_ERR_CNT_EN
    u_if.Err_Cnt_Clr = 1'b1;
    @(negedge CLK);
    u_if.Err_Cnt_Clr = 1'b0;
    check("E_cnt_clr", {16'd0, u_if.Glitch_Cnt, u_if.Frame_Err_Cnt}, 32'd0);
`endif

    // F: back-to-back frames, second start on first IDLE cycle
    t = cyc; d0 = dv_n;
    frame(8'd8, 8, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 81);
    frame(8'd8, 8, 1'b0, 8'hED, 1'b0, 1'b0, 1'b0, 81);
    check("F_dv_cnt", 32'(dv_n - d0), 32'd2);
    check("F_dv_gap", 32'(dv_at - dv_prev), 32'd81);
    check("F_dv_at", 32'(dv_at - t), 32'd162);
    idle_inputs();
    @(negedge CLK);

    // G: reset in DATA at Bit_Cnt=4, then a frame with Prescale=3 (-> 8)
    d0 = dv_n; p0 = pe_n; f0 = fe_n;
    frame(8'd8, 8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 45);
    check("G_bitcnt4", {28'd0, u_if.Bit_Cnt}, 32'd4);
    #2 RST = 1'b0;
    #1 check("G_async_rst", outs(), 32'd0);
    idle_inputs();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    t = cyc;
    frame(8'd3, 8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 81);
    check("G_dv_cnt", 32'(dv_n - d0), 32'd1);
    check("G_dv_at", 32'(dv_at - t), 32'd81);
    check("G_no_err", 32'((pe_n - p0) + (fe_n - f0)), 32'd0);
    idle_inputs();
    @(negedge CLK);
    check("G_idle", outs(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-sequencing controller for the UART receiver. It owns the per-bit edge counter and the frame bit counter. It drives the enables of the Rx datapath sub-blocks: sampler, start-glitch checker, deserializer, parity checker and stop checker. It consumes their error flags and issues a one-cycle Data_Valid, or an error pulse, per frame.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..9)

Ports:
CLK  input  1  system clock; all state on rising edge
RST  input  1  asynchronous active-low reset
RX_IN  input  1  synchronized serial line; idle high
Prescale  input  8  oversampling ratio, clock cycles per bit
PAR_EN  input  1  1 = frame carries a parity bit
Strt_Glitch  input  1  from start checker; 1 = start bit sampled high
Par_Err  input  1  from parity checker; valid while Par_Chk_En
Stp_Err  input  1  from stop checker; valid while Stp_Chk_En
Edge_Cnt  output  8  cycle index within current bit, 0..Prescale-1
Bit_Cnt  output  4  data-bit index within DATA state
Samp_En  output  1  sampler enable
Strt_Chk_En  output  1  start checker enable
Deser_En  output  1  one-cycle shift strobe to deserializer
Par_Chk_En  output  1  parity checker enable
Stp_Chk_En  output  1  stop checker enable
Data_Valid  output  1  one-cycle pulse; deserializer holds a good byte
Parity_Err  output  1  one-cycle pulse; frame dropped for parity
Framing_Err  output  1  one-cycle pulse; frame dropped for stop bit
Busy  output  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all outputs and counters 0; latched Prescale = 8; latched PAR_EN = 0; sticky parity flag = 0.
- Effective prescale P:
  - Prescale and PAR_EN are latched on the IDLE->START transition. Mid-frame changes are ignored.
  - Prescale < 8 is latched as 8.
- Edge_Cnt:
  - Held at 0 in IDLE.
  - In the other states it increments each cycle.
  - At Edge_Cnt == P-1 ("bit boundary") it wraps to 0 on the next cycle.
- States: IDLE, START, DATA, PARITY, STOP. Moore enables, decoded from registered state.
- IDLE:
  - RX_IN == 0 in cycle t -> START at t+1 with Edge_Cnt = 0.
  - Busy = 0.
- START:
  - Samp_En = 1, Strt_Chk_En = 1.
  - At bit boundary: Strt_Glitch == 1 -> IDLE, no pulse. Otherwise -> DATA with Bit_Cnt = 0.
- DATA:
  - Samp_En = 1.
  - Deser_En pulses for one cycle when Edge_Cnt == (P>>1)+3, i.e. the cycle after the majority sample is registered.
  - At bit boundary: if Bit_Cnt == DATA_WIDTH-1, go to PARITY when latched PAR_EN = 1, else STOP. Otherwise Bit_Cnt increments.
- PARITY:
  - Samp_En = 1, Par_Chk_En = 1.
  - Par_Err observed at the bit boundary is captured into the sticky flag; then -> STOP.
- STOP:
  - Samp_En = 1, Stp_Chk_En = 1.
  - At bit boundary -> IDLE, and exactly one of the following is registered high for one cycle:
    - Framing_Err, if Stp_Err = 1. Takes priority over a parity error.
    - else Parity_Err, if the sticky flag = 1.
    - else Data_Valid.
  - The sticky flag clears on entry to IDLE.
- Latency:
  - Falling edge sampled at cycle t.
  - Result pulse at t+1+N*P, where N = 2+DATA_WIDTH+PAR_EN.
- Back-to-back frames: a low RX_IN on the first IDLE cycle after STOP starts the next frame. There is no extra dead cycle beyond that IDLE cycle.
- Reset mid-frame: immediate return to IDLE. No pulse is issued and all enables drop asynchronously.

Optional Feature:
UART_RX_ERR_CNT_EN:
- When defined, adds:
  - input Err_Cnt_Clr (1)
  - output Glitch_Cnt (8)
  - output Frame_Err_Cnt (8)
- Both counters are 8-bit saturating at 255 and reset to 0.
- Glitch_Cnt increments on every START->IDLE abort.
- Frame_Err_Cnt increments on every Framing_Err pulse.
- Err_Cnt_Clr zeroes both counters and wins over a simultaneous increment.
- When undefined, the ports and logic are absent. Core behaviour is identical.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5, good stop, RX_IN falls at cycle t -> Data_Valid single pulse at t+81; 8 Deser_En pulses at Edge_Cnt=7; Busy low at t+82.
- Prescale=16, PAR_EN=1, Par_Err forced 1 during PARITY, Stp_Err=0 -> Parity_Err pulse at t+177; no Data_Valid.
- Prescale=8, Strt_Glitch=1 at START boundary -> return to IDLE at t+9; no pulse. With UART_RX_ERR_CNT_EN, Glitch_Cnt 0->1.
- Prescale=8, PAR_EN=1, both Par_Err and Stp_Err =1 -> Framing_Err only at t+89; sticky flag cleared before the next frame.
- Two frames back-to-back, second start low immediately after STOP -> two Data_Valid pulses 81 cycles apart (Prescale=8, PAR_EN=0).
- RST asserted in DATA at Bit_Cnt=4 -> all outputs 0 asynchronously. After release, a full good frame yields Data_Valid at nominal latency. Prescale=3 latched as 8.
